kernel_nios2_mult_unit: RTL and testbench
=========================================

# kernel_nios2_mult_unit

Parametrised, pipelined integer multiplier for the Nios II execute path. It computes the low or high word of a DATA_W×DATA_W product in signed/unsigned combinations, covering mul, mulxss, mulxsu and mulxuu. Four registered half-width partial products feed a summing stage, followed by an optional output pipeline. It sits beside the ALU in the A stage, with a valid/tag sideband and a global pipeline enable for stalls.

## Interface
- DATA_W, 32: operand/result width; even, ≥ 8.
- OUT_REGS, 0: extra output register stages, 0..2.
- TAG_W, 5: sideband tag width (destination register index).
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- ena  in  1  pipeline enable; low = every register holds.
- in_valid  in  1  operands/op valid this cycle (sampled when ena=1).
- in_op  in  2  00 MUL (low word), 01 MULXSS, 10 MULXSU, 11 MULXUU (high word).
- in_src1  in  DATA_W  operand A (signed for MULXSS/MULXSU).
- in_src2  in  DATA_W  operand B (signed for MULXSS only).
- in_tag  in  TAG_W  carried unchanged to out_tag.
- out_valid  out  1  result valid.
- out_result  out  DATA_W  selected product word.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Full product P = A×B, 2·DATA_W bits, exact. Operand interpretation per in_op: MUL and MULXUU unsigned×unsigned; MULXSS signed×signed; MULXSU signed A × unsigned B.
- MUL returns P[DATA_W-1:0], which is independent of signedness. MULX* return P[2·DATA_W-1:DATA_W].
- Stage 1 (P1): register the four H = DATA_W/2 partial products lo·lo, hi·lo, lo·hi, hi·hi. Sign correction for signed operands is applied to the hi halves, using (H+1)-bit extended multiplicands. Also register op, tag and valid.
- Stage 2 (P2): sum the partials with shifts, select the word, register the result, tag and valid.
- Output stages: OUT_REGS further copies of {valid, tag, result}.
- Valid bubbles propagate. Result and tag registers load whenever ena=1, regardless of valid; consumers qualify them with out_valid.
- No backpressure: one operation is accepted per enabled cycle and there is no internal buffering.

## Timing
- Latency L = 2 + OUT_REGS enabled cycles from in_valid sample to out_valid.
- Throughput: one operation per enabled cycle, with back-to-back issue allowed.
- ena=0: all stages freeze and outputs hold their values. Latency counts enabled edges only.
- Reset (reset_n=0 at a clock edge): all valid bits go to 0, and out_result, out_tag and all internal data go to 0. Reset has priority over ena.
- Reset mid-operation: in-flight operations are discarded and never emerge. The first input sampled after reset deasserts appears L enabled cycles later.
- in_valid=0 inputs: out_valid=0 at the corresponding output slot. Data values there are don't-care but deterministic.
- Arithmetic: no overflow flag. MUL wraps modulo 2^DATA_W.
- Boundaries: a zero operand gives 0. The most negative value squared under MULXSS gives 2^(DATA_W-2) in the high word (DATA_W=32: 0x40000000).

## Configuration
- KERNEL_NIOS2_MULT_HI_EN defined: behaviour exactly as above, with all four in_op codes supported.
- Not defined: the hi·hi partial product and the sign correction are omitted, and only the low word is computed. Every in_op code returns P[DATA_W-1:0]. Latency, handshake and reset behaviour are unchanged.

## Test plan
- DATA_W=32, HI_EN defined. A=B=0xFFFFFFFF issued back-to-back with ops 00, 11, 01, 10 → on consecutive cycles from cycle 2: 0x00000001, 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF. Tags 1..4 are preserved.
- A=0x80000000, B=0x80000000, MULXSS → 0x40000000; MUL → 0x00000000. A=0x12345678, B=0x9ABCDEF0, MUL → 0x242D2080.
- ena low for 3 cycles with two operations in flight → outputs frozen. Results emerge on the 2nd enabled edge after issue, unchanged.
- reset_n low for 1 cycle while two valid operations are in flight → out_valid stays 0 and out_result=0. A fresh operation after reset emerges exactly L cycles later.
- OUT_REGS=2, alternating in_valid 1/0 → out_valid pattern delayed exactly 4 cycles.
- HI_EN undefined, A=B=0xFFFFFFFF, op 11 → 0x00000001.

Source files
------------

// File: rtl/kernel_nios2_mult_unit.sv
// Pipelined DATA_W x DATA_W multiplier for the Nios II execute path (mul, mulxss, mulxsu, mulxuu).
// Define KERNEL_NIOS2_MULT_HI_EN to build the high-word datapath; otherwise every op returns the low word.
module kernel_nios2_mult_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OUT_REGS = 0,
  parameter int unsigned TAG_W    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int unsigned H      = DATA_W / 2;
  localparam int unsigned LLW    = 2 * H;
  localparam int unsigned NS     = OUT_REGS + 1;
  localparam int unsigned TW_ALL = NS * TAG_W;
  localparam int unsigned RW_ALL = NS * DATA_W;

  logic             p1_valid;
  logic [TAG_W-1:0] p1_tag;
  logic [LLW-1:0]   p1_ll;
  logic [DATA_W-1:0] word_c;

`ifdef KERNEL_NIOS2_MULT_HI_EN
  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned XW = 2 * H + 2;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;

  logic              a_sgn_c, b_sgn_c;
  logic signed [H:0] a_hi_c, a_lo_c, b_hi_c, b_lo_c;
  logic [1:0]        p1_op;
  logic signed [XW-1:0] p1_hl, p1_lh, p1_hh;
  logic [PW-1:0]     prod_c;

  // Half-width operands widened by one bit; only hi halves of signed operands carry the sign.
  always_comb begin
    a_sgn_c = (in_op == OP_MULXSS) || (in_op == OP_MULXSU);
    b_sgn_c = (in_op == OP_MULXSS);
    a_hi_c  = {a_sgn_c & in_src1[DATA_W-1], in_src1[DATA_W-1:H]};
    a_lo_c  = {1'b0, in_src1[H-1:0]};
    b_hi_c  = {b_sgn_c & in_src2[DATA_W-1], in_src2[DATA_W-1:H]};
    b_lo_c  = {1'b0, in_src2[H-1:0]};
  end
`else
  logic [H-1:0] p1_hl, p1_lh;
  logic         unused_op;
  assign unused_op = ^in_op;
`endif

  // Stage 1: partial products plus sideband.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p1_valid <= 1'b0;
      p1_tag   <= '0;
      p1_ll    <= '0;
      p1_hl    <= '0;
      p1_lh    <= '0;
`ifdef KERNEL_NIOS2_MULT_HI_EN
      p1_hh    <= '0;
      p1_op    <= '0;
`endif
    end else if (ena) begin
      p1_valid <= in_valid;
      p1_tag   <= in_tag;
      p1_ll    <= LLW'(in_src1[H-1:0]) * LLW'(in_src2[H-1:0]);
`ifdef KERNEL_NIOS2_MULT_HI_EN
      p1_hl    <= XW'(a_hi_c) * XW'(b_lo_c);
      p1_lh    <= XW'(a_lo_c) * XW'(b_hi_c);
      p1_hh    <= XW'(a_hi_c) * XW'(b_hi_c);
      p1_op    <= in_op;
`else
      p1_hl    <= in_src1[DATA_W-1:H] * in_src2[H-1:0];
      p1_lh    <= in_src1[H-1:0] * in_src2[DATA_W-1:H];
`endif
    end
  end

  // Stage 2 sum: signed cross terms sign-extend to the full product width before shifting.
`ifdef KERNEL_NIOS2_MULT_HI_EN
  always_comb begin
    prod_c = PW'(p1_ll) + (PW'(p1_hl) << H) + (PW'(p1_lh) << H) + (PW'(p1_hh) << LLW);
    word_c = (p1_op == OP_MUL) ? prod_c[DATA_W-1:0] : prod_c[PW-1:DATA_W];
  end
`else
  always_comb begin
    word_c = p1_ll + {p1_hl + p1_lh, {H{1'b0}}};
  end
`endif

  // Stage 2 register followed by OUT_REGS copies; newest slot sits at the low end.
  logic [NS-1:0]     o_valid;
  logic [TW_ALL-1:0] o_tag;
  logic [RW_ALL-1:0] o_res;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid <= '0;
      o_tag   <= '0;
      o_res   <= '0;
    end else if (ena) begin
      o_valid <= NS'({o_valid, p1_valid});
      o_tag   <= TW_ALL'({o_tag, p1_tag});
      o_res   <= RW_ALL'({o_res, word_c});
    end
  end

  assign out_valid  = o_valid[NS-1];
  assign out_tag    = o_tag[TW_ALL-1 -: TAG_W];
  assign out_result = o_res[RW_ALL-1 -: DATA_W];

endmodule

// File: tb/tb_kernel_nios2_mult_unit.sv
// Self-checking bench for kernel_nios2_mult_unit: OUT_REGS=0 and OUT_REGS=2 instances side by side,
// checked against an arithmetic reference and a latency history of sampled operations.
module tb_kernel_nios2_mult_unit;
  logic        clk;
  logic        reset_n;
  logic        ena;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_tag;
  logic        out0_valid, out2_valid;
  logic [31:0] out0_result, out2_result;
  logic [4:0]  out0_tag, out2_tag;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        valid;
    logic        chk;
    logic [4:0]  tag;
    logic [31:0] result;
  } slot_t;

  // hist[k] = operation sampled k enabled edges ago; latency-L output shows hist[L-1].
  slot_t hist [4];

  kernel_nios2_mult_unit #(.DATA_W(32), .OUT_REGS(0), .TAG_W(5)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out0_valid), .out_result(out0_result), .out_tag(out0_tag)
  );

  kernel_nios2_mult_unit #(.DATA_W(32), .OUT_REGS(2), .TAG_W(5)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out2_valid), .out_result(out2_result), .out_tag(out2_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
`ifdef KERNEL_NIOS2_MULT_HI_EN
    return (op == 2'b00) ? p[31:0] : p[63:32];
`else
    return p[31:0];
`endif
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle of inputs, advance one edge, update the history, settle 1 time unit.
  task automatic step(input logic rn, input logic en, input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    reset_n = rn; ena = en; in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_tag = t;
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 1'b1, 5'd0, 32'd0};
    end else if (en) begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{v, v, t, ref_mul(op, a, b)};
    end
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom));
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, 2'b00, 32'h1234, 32'h5678, 5'd9);
    step(1'b0, 1'b0, 1'b1, 2'b01, 32'h1234, 32'h5678, 5'd9);
    if (out0_valid !== 1'b0 || out0_result !== 32'd0 || out0_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset0: got v=%b r=%h t=%h, want 0/0/0", out0_valid, out0_result, out0_tag);
    end
    checks++;
    if (out2_valid !== 1'b0 || out2_result !== 32'd0 || out2_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset2: got v=%b r=%h t=%h, want 0/0/0", out2_valid, out2_result, out2_tag);
    end
    checks++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'h80000000, 32'h12345678};
    logic [31:0] tb [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'h80000000, 32'h9ABCDEF0};
    logic [1:0]  to [7] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
`ifdef KERNEL_NIOS2_MULT_HI_EN
    logic [31:0] te [7] = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF,
                            32'h40000000, 32'h00000000, 32'h242D2080};
`else
    logic [31:0] te [7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                            32'h00000000, 32'h00000000, 32'h242D2080};
`endif
    int k = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) step(1'b1, 1'b1, 1'b1, to[i], ta[i], tb[i], 5'(i + 1));
      else idle();
      if (out0_valid !== hist[1].valid || (hist[1].chk && (out0_result !== hist[1].result || out0_tag !== hist[1].tag))) begin
        errors++;
        $display("FAIL directed_model cyc=%0d: got v=%b r=%h t=%h, want v=%b r=%h t=%h",
                 i, out0_valid, out0_result, out0_tag, hist[1].valid, hist[1].result, hist[1].tag);
      end
      checks++;
      if (out0_valid === 1'b1) begin
        if (k >= 7 || out0_result !== te[k] || out0_tag !== 5'(k + 1)) begin
          errors++;
          $display("FAIL directed_const #%0d: got r=%h t=%0d, want r=%h t=%0d",
                   k, out0_result, out0_tag, (k < 7) ? te[k] : 32'd0, k + 1);
        end
        checks++;
        k++;
      end
    end
    if (k != 7) begin
      errors++;
      $display("FAIL directed_count: got %0d results, want 7", k);
    end
    checks++;
  endtask

  task automatic test_stall();
    logic        sv;
    logic [31:0] sr;
    logic [4:0]  st;
    step(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'd11);
    step(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'd12);
    sv = out0_valid; sr = out0_result; st = out0_tag;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 2'b11, $urandom, $urandom, 5'd31);
      if (out0_valid !== sv || out0_result !== sr || out0_tag !== st) begin
        errors++;
        $display("FAIL stall_frozen cyc=%0d: got v=%b r=%h t=%h, want v=%b r=%h t=%h",
                 i, out0_valid, out0_result, out0_tag, sv, sr, st);
      end
      checks++;
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      if (out0_valid !== hist[1].valid || (hist[1].chk && (out0_result !== hist[1].result || out0_tag !== hist[1].tag))) begin
        errors++;
        $display("FAIL stall_resume cyc=%0d: got v=%b r=%h t=%h, want v=%b r=%h t=%h",
                 i, out0_valid, out0_result, out0_tag, hist[1].valid, hist[1].result, hist[1].tag);
      end
      checks++;
    end
  endtask

  task automatic test_reset_flight();
    logic [31:0] a, b, want;
    int lat0 = 0, lat2 = 0;
    step(1'b1, 1'b1, 1'b1, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 5'd3);
    step(1'b1, 1'b1, 1'b1, 2'b00, 32'h0BADF00D, 32'h00000007, 5'd4);
    step(1'b0, 1'b1, 1'b1, 2'b01, 32'h11111111, 32'h22222222, 5'd5);
    if (out0_valid !== 1'b0 || out0_result !== 32'd0 || out2_valid !== 1'b0 || out2_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_flight_clear: got v0=%b r0=%h v2=%b r2=%h, want 0/0/0/0",
               out0_valid, out0_result, out2_valid, out2_result);
    end
    checks++;
    a = rnd_operand(); b = rnd_operand();
    want = ref_mul(2'b01, a, b);
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) step(1'b1, 1'b1, 1'b1, 2'b01, a, b, 5'd21);
      else idle();
      if (out0_valid === 1'b1 && lat0 == 0) begin
        lat0 = i;
        if (out0_result !== want || out0_tag !== 5'd21) begin
          errors++;
          $display("FAIL reset_flight_data0: got r=%h t=%0d, want r=%h t=21", out0_result, out0_tag, want);
        end
        checks++;
      end
      if (out2_valid === 1'b1 && lat2 == 0) lat2 = i;
    end
    if (lat0 != 2 || lat2 != 4) begin
      errors++;
      $display("FAIL reset_flight_latency: got L0=%0d L2=%0d, want 2 and 4 (0 = never seen)", lat0, lat2);
    end
    checks++;
  endtask

  task automatic test_bubbles();
    logic vpat [16];
    for (int i = 0; i < 16; i++) begin
      vpat[i] = (i < 12) ? ((i % 2) == 0) : 1'b0;
      step(1'b1, 1'b1, vpat[i], 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'($urandom));
      if (i >= 3 && out2_valid !== vpat[i-3]) begin
        errors++;
        $display("FAIL bubbles_delay2 cyc=%0d: got v=%b, want %b", i, out2_valid, vpat[i-3]);
      end
      if (i >= 3) checks++;
      if (out2_valid !== hist[3].valid || (hist[3].chk && (out2_result !== hist[3].result || out2_tag !== hist[3].tag))) begin
        errors++;
        $display("FAIL bubbles_model2 cyc=%0d: got v=%b r=%h t=%h, want v=%b r=%h t=%h",
                 i, out2_valid, out2_result, out2_tag, hist[3].valid, hist[3].result, hist[3].tag);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'($urandom));
      if (out0_valid !== hist[1].valid || (hist[1].chk && (out0_result !== hist[1].result || out0_tag !== hist[1].tag))) begin
        errors++;
        $display("FAIL random0 cyc=%0d: got v=%b r=%h t=%h, want v=%b r=%h t=%h",
                 i, out0_valid, out0_result, out0_tag, hist[1].valid, hist[1].result, hist[1].tag);
      end
      checks++;
      if (out2_valid !== hist[3].valid || (hist[3].chk && (out2_result !== hist[3].result || out2_tag !== hist[3].tag))) begin
        errors++;
        $display("FAIL random2 cyc=%0d: got v=%b r=%h t=%h, want v=%b r=%h t=%h",
                 i, out2_valid, out2_result, out2_tag, hist[3].valid, hist[3].result, hist[3].tag);
      end
      checks++;
    end
  endtask

  initial begin
    reset_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_src1 = 32'd0; in_src2 = 32'd0; in_tag = 5'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_reset_flight();
    test_bubbles();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
